// File: rtl/ysyx_23060201_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_23060201_fetch_pkg : shared encodings for the fetch unit         |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package ysyx_23060201_fetch_pkg;

  localparam logic [31:0] c_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] c_INST_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_KEEP  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_TGT   = 2'd3
  } pc_sel_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060201_fetch_pc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_23060201_fetch_pc : pc, pending redirect target and drop flag    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ysyx_23060201_fetch_pc
  import ysyx_23060201_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = c_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  pc_sel_e           i_sel,
  input  logic              i_set_drop,
  input  logic              i_clr_drop,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_drop
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_tgt;
  logic              r_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_tgt  <= RESET_PC;
      r_drop <= 1'b0;
    end else begin
      case (i_sel)
        PC_INC:   r_pc <= r_pc + ADDR_W'(4);
        PC_REDIR: r_pc <= i_redirect_pc;
        PC_TGT:   r_pc <= r_tgt;
        default:  r_pc <= r_pc;
      endcase
      // a newer redirect always overwrites the pending target
      if (i_set_drop) begin
        r_drop <= 1'b1;
        r_tgt  <= i_redirect_pc;
      end else if (i_clr_drop) begin
        r_drop <= 1'b0;
      end
    end
  end

  assign o_pc   = r_pc;
  assign o_drop = r_drop;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060201_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_23060201_fetch : single-outstanding instruction fetch unit       |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ysyx_23060201_fetch
  import ysyx_23060201_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = c_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_imem_req_valid,
  input  logic              i_imem_req_ready,
  output logic [ADDR_W-1:0] o_imem_req_addr,
  input  logic              i_imem_resp_valid,
  input  logic [31:0]       i_imem_resp_data,
  input  logic              i_imem_resp_err,
  output logic              o_imem_resp_ready,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_fetch_err
);

  fetch_state_e      r_state;
  logic              r_inst_valid;
  logic [31:0]       r_inst;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_fetch_err;

  logic [ADDR_W-1:0] w_pc;
  logic              w_drop;
  logic              w_misalign;
  logic              w_redir_ok;
  logic              w_resp_dropped;
  pc_sel_e           w_sel;
  logic              w_set_drop;
  logic              w_clr_drop;

  assign w_misalign     = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
  assign w_redir_ok     = i_redirect_valid && !w_misalign;
  // a redirect arriving with the response also makes that response stale
  assign w_resp_dropped = w_drop || w_redir_ok;

  always_comb begin
    w_sel      = PC_KEEP;
    w_set_drop = 1'b0;
    w_clr_drop = 1'b0;
    case (r_state)
      S_BOOT: if (w_redir_ok) w_sel = PC_REDIR;
      S_REQ:  w_set_drop = w_redir_ok;
      S_WAIT: begin
        if (i_imem_resp_valid && w_resp_dropped) begin
          w_sel      = w_redir_ok ? PC_REDIR : PC_TGT;
          w_clr_drop = 1'b1;
        end else begin
          w_set_drop = w_redir_ok;
        end
      end
      S_HOLD: begin
        if (w_redir_ok)        w_sel = PC_REDIR;
        else if (i_inst_ready) w_sel = PC_INC;
      end
      default: w_sel = PC_KEEP;
    endcase
  end

  ysyx_23060201_fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst           (rst),
    .i_sel         (w_sel),
    .i_set_drop    (w_set_drop),
    .i_clr_drop    (w_clr_drop),
    .i_redirect_pc (i_redirect_pc),
    .o_pc          (w_pc),
    .o_drop        (w_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_inst_valid <= 1'b0;
      r_inst       <= c_INST_NOP;
      r_inst_pc    <= RESET_PC;
      r_fetch_err  <= 1'b0;
    end else if (w_misalign && (r_state != S_HALT)) begin
      r_fetch_err  <= 1'b1;
      r_inst_valid <= 1'b0;
      r_state      <= S_HALT;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_REQ;
        S_REQ:  if (i_imem_req_ready) r_state <= S_WAIT;
        S_WAIT: begin
          if (i_imem_resp_valid) begin
            if (w_resp_dropped) begin
              r_state <= S_REQ;
            end else if (i_imem_resp_err) begin
              r_fetch_err <= 1'b1;
              r_state     <= S_HALT;
            end else begin
              r_inst       <= i_imem_resp_data;
              r_inst_pc    <= w_pc;
              r_inst_valid <= 1'b1;
              r_state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_redir_ok || i_inst_ready) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_REQ;
          end
        end
        default: begin
          r_inst_valid <= 1'b0;
          r_state      <= S_HALT;
        end
      endcase
    end
  end

  assign o_imem_req_valid  = (r_state == S_REQ);
  assign o_imem_resp_ready = (r_state == S_WAIT);
  assign o_imem_req_addr   = w_pc;
  assign o_inst_valid      = r_inst_valid;
  assign o_inst            = r_inst;
  assign o_inst_pc         = r_inst_pc;
  assign o_fetch_err       = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060201_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ysyx_23060201_fetch : fetch unit bench with memory and pc model    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_ysyx_23060201_fetch;

  localparam logic [31:0] c_RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        o_imem_req_valid, i_imem_req_ready;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_resp_valid, i_imem_resp_err, o_imem_resp_ready;
  logic [31:0] i_imem_resp_data;
  logic        o_inst_valid, i_inst_ready;
  logic [31:0] o_inst, o_inst_pc;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_fetch_err;

  ysyx_23060201_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .o_imem_req_valid  (o_imem_req_valid),
    .i_imem_req_ready  (i_imem_req_ready),
    .o_imem_req_addr   (o_imem_req_addr),
    .i_imem_resp_valid (i_imem_resp_valid),
    .i_imem_resp_data  (i_imem_resp_data),
    .i_imem_resp_err   (i_imem_resp_err),
    .o_imem_resp_ready (o_imem_resp_ready),
    .o_inst_valid      (o_inst_valid),
    .i_inst_ready      (i_inst_ready),
    .o_inst            (o_inst),
    .o_inst_pc         (o_inst_pc),
    .i_redirect_valid  (i_redirect_valid),
    .i_redirect_pc     (i_redirect_pc),
    .o_fetch_err       (o_fetch_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // memory model state
  bit          m_pend;
  int          m_dly;
  logic [31:0] m_data;
  bit          m_err;
  int          cfg_dly     = 0;
  int          cfg_rdy_pct = 100;
  bit          cfg_err     = 0;
  bit          cfg_ovr_en  = 0;
  logic [31:0] cfg_ovr     = 32'h0;

  // architectural model: the pc the next delivered instruction must carry
  logic [31:0] exp_pc;
  bit          hold_prev;
  logic [31:0] prev_inst, prev_pc;
  logic [31:0] pres_pc[$];
  int          pres_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  // called at a negedge: check current outputs, drive next inputs, advance one cycle
  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    if (hold_prev) begin
      check("hold_valid", {31'b0, o_inst_valid}, 32'd1);
      check("hold_inst", o_inst, prev_inst);
      check("hold_pc", o_inst_pc, prev_pc);
      check("hold_noreq", {31'b0, o_imem_req_valid}, 32'd0);
    end else if (o_inst_valid) begin
      check("inst_pc", o_inst_pc, exp_pc);
      check("inst_data", o_inst, memf(exp_pc));
      pres_pc.push_back(o_inst_pc);
      pres_cyc.push_back(cyc);
    end
    i_redirect_valid = rv;
    i_redirect_pc    = rpc;
    i_inst_ready     = rdy;
    i_imem_resp_valid = 1'b0;
    i_imem_resp_data  = 32'h0;
    i_imem_resp_err   = 1'b0;
    if (m_pend) begin
      if (m_dly > 0) m_dly--;
      else begin
        i_imem_resp_valid = 1'b1;
        i_imem_resp_data  = m_data;
        i_imem_resp_err   = m_err;
        if (o_imem_resp_ready) m_pend = 0;
      end
    end
    i_imem_req_ready = ($urandom_range(99) < cfg_rdy_pct);
    if (o_imem_req_valid && i_imem_req_ready) begin
      m_pend     = 1;
      m_dly      = (cfg_dly < 0) ? int'($urandom_range(3)) : cfg_dly;
      m_data     = cfg_ovr_en ? cfg_ovr : memf(o_imem_req_addr);
      m_err      = cfg_err;
      cfg_ovr_en = 0;
      cfg_err    = 0;
    end
    if (rv && rpc[1:0] == 2'b00) exp_pc = rpc;
    else if (o_inst_valid && rdy) exp_pc = exp_pc + 32'd4;
    hold_prev = o_inst_valid && !rdy && !rv;
    prev_inst = o_inst;
    prev_pc   = o_inst_pc;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_redirect_valid = 1'b0; i_redirect_pc = 32'h0; i_inst_ready = 1'b0;
    i_imem_req_ready = 1'b0; i_imem_resp_valid = 1'b0;
    i_imem_resp_data = 32'h0; i_imem_resp_err = 1'b0;
    m_pend = 0; cfg_err = 0; cfg_ovr_en = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = c_RST_PC; hold_prev = 0;
    pres_pc.delete(); pres_cyc.delete();
    cyc = 0;
  endtask

  task automatic wait_present(input bit rdy);
    int n = 0;
    while (!o_inst_valid && n < 30) begin
      step(1'b0, 32'h0, rdy);
      n++;
    end
    check("present_timeout", {31'b0, o_inst_valid}, 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!o_imem_req_valid && n < 30) begin
      step(1'b0, 32'h0, 1'b1);
      n++;
    end
    check(tag, {31'b0, o_imem_req_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] p;
    int n;
    @(negedge clk);
    do_reset();
    check("rst_inst_valid", {31'b0, o_inst_valid}, 32'd0);
    check("rst_inst", o_inst, 32'h0000_0013);
    check("rst_inst_pc", o_inst_pc, c_RST_PC);
    check("rst_fetch_err", {31'b0, o_fetch_err}, 32'd0);
    check("rst_req_valid", {31'b0, o_imem_req_valid}, 32'd0);
    check("rst_resp_ready", {31'b0, o_imem_resp_ready}, 32'd0);

    // zero-wait streaming
    cfg_dly = 0; cfg_rdy_pct = 100;
    step(1'b0, 32'h0, 1'b1);
    check("t1_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
    check("t1_req_addr", o_imem_req_addr, c_RST_PC);
    repeat (9) step(1'b0, 32'h0, 1'b1);
    check("t1_count", pres_pc.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < pres_pc.size()) check("t1_pc", pres_pc[i], c_RST_PC + 32'(4 * i));
    if (pres_cyc.size() >= 3) begin
      check("t1_gap0", pres_cyc[1] - pres_cyc[0], 32'd3);
      check("t1_gap1", pres_cyc[2] - pres_cyc[1], 32'd3);
    end

    // decode back-pressure
    wait_present(1'b0);
    p = o_inst_pc;
    repeat (5) step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    check("t2_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
    check("t2_req_addr", o_imem_req_addr, p + 32'd4);

    // redirect while waiting on a slow response
    cfg_dly = 4; cfg_ovr_en = 1; cfg_ovr = 32'hDEAD_BEEF;
    step(1'b0, 32'h0, 1'b1);
    check("t3_in_wait", {31'b0, o_imem_resp_ready}, 32'd1);
    cfg_dly = 0;
    step(1'b1, 32'h8000_0100, 1'b1);
    wait_req("t3_req_timeout");
    check("t3_req_addr", o_imem_req_addr, 32'h8000_0100);
    wait_present(1'b1);
    check("t3_inst_pc", o_inst_pc, 32'h8000_0100);

    // redirect together with inst_ready in HOLD
    step(1'b1, 32'h8000_0040, 1'b1);
    check("t4_valid_drop", {31'b0, o_inst_valid}, 32'd0);
    check("t4_req_valid", {31'b0, o_imem_req_valid}, 32'd1);
    check("t4_req_addr", o_imem_req_addr, 32'h8000_0040);

    // access fault then reset recovery
    cfg_err = 1;
    n = 0;
    while (!o_fetch_err && n < 10) begin
      step(1'b0, 32'h0, 1'b1);
      n++;
    end
    check("t5_fetch_err", {31'b0, o_fetch_err}, 32'd1);
    repeat (4) begin
      step(1'b0, 32'h0, 1'b1);
      check("t5_halt_noreq", {31'b0, o_imem_req_valid}, 32'd0);
    end
    check("t5_halt_noinst", {31'b0, o_inst_valid}, 32'd0);
    do_reset();
    check("t5_err_clr", {31'b0, o_fetch_err}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("t5_restart_addr", o_imem_req_addr, c_RST_PC);

    // misaligned redirect
    wait_present(1'b0);
    step(1'b1, 32'h8000_0102, 1'b0);
    check("t6_misalign_err", {31'b0, o_fetch_err}, 32'd1);
    check("t6_misalign_inst", {31'b0, o_inst_valid}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("t6_misalign_noreq", {31'b0, o_imem_req_valid}, 32'd0);

    // pc wrap
    do_reset();
    wait_present(1'b0);
    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    check("t6_top_addr", o_imem_req_addr, 32'hFFFF_FFFC);
    wait_present(1'b0);
    step(1'b0, 32'h0, 1'b1);
    check("t6_wrap_valid", {31'b0, o_imem_req_valid}, 32'd1);
    check("t6_wrap_addr", o_imem_req_addr, 32'h0000_0000);

    // randomized traffic against the pc model
    do_reset();
    cfg_dly = -1; cfg_rdy_pct = 60;
    for (int i = 0; i < 800; i++)
      step($urandom_range(9) == 0, $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(1)));
    check("rand_no_err", {31'b0, o_fetch_err}, 32'd0);
    check("rand_progress", {31'b0, pres_pc.size() > 20}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
